// File: rtl/bram_stream_reader_pkg.sv
// -----------------------------------------------------------------------------
// bram_stream_reader_pkg
// Shared definitions for the coefficient-BRAM stream reader:
//   - default word / address widths (kept identical to the BRAM wrapper)
//   - depth of the read-return skid FIFO and the width of its occupancy count
//   - the reader FSM state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package bram_stream_reader_pkg;

    localparam int DATA_WIDTH_DEF = 18;
    localparam int ADDR_WIDTH_DEF = 10;

    // Two entries cover the one word that may already be in flight in the
    // BRAM pipeline plus the word sitting at the stream head.
    localparam int SKID_DEPTH = 2;
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } rd_state_e;

endpackage

// File: rtl/bram_stream_reader_if.sv
// -----------------------------------------------------------------------------
// bram_stream_reader_if
// Valid/ready stream carrying coefficient words with an end-of-sweep flag.
//   m_data  : word at the stream head
//   m_valid : head word is valid
//   m_last  : head word is the final word of the sweep
//   m_ready : consumer accepts the head word this cycle
// Modports: master (producer side), slave (consumer side).
// -----------------------------------------------------------------------------
interface bram_stream_reader_if
    import bram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_last;
    logic                  m_ready;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/bram_rd_skid.sv
// -----------------------------------------------------------------------------
// bram_rd_skid
// Small register FIFO (SKID_DEPTH entries) holding {last, data} words returned
// by the BRAM until the downstream stream accepts them. Entry 0 is always the
// head, so the head outputs come straight from a register.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   push_i       : write {push_last_i, push_data_i} this cycle
//   pop_i        : head word is consumed this cycle (only when count_o != 0)
//   count_o      : number of valid entries
//   head_data_o  : data of entry 0
//   head_last_o  : last flag of entry 0
// Push and pop in the same cycle are allowed; the caller guarantees no push
// into a full FIFO unless it also pops.
// -----------------------------------------------------------------------------
module bram_rd_skid
    import bram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  push_last_i,
    input  logic                  pop_i,
    output logic [SKID_CNT_W-1:0] count_o,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic                  head_last_o
);

    localparam int EW = DATA_WIDTH + 1;

    logic [SKID_CNT_W-1:0]           count_q;
    logic [SKID_CNT_W-1:0]           wr_idx;
    logic [SKID_DEPTH-1:0][EW-1:0]   entry_w;

    // A pop shifts every entry down by one, so a simultaneous push lands one
    // slot lower than it would without the pop.
    assign wr_idx = count_q - SKID_CNT_W'(pop_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + SKID_CNT_W'(push_i) - SKID_CNT_W'(pop_i);
        end
    end

    generate
        for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
            logic [EW-1:0] entry_q;
            logic [EW-1:0] shift_in;

            if (gi + 1 < SKID_DEPTH) begin : g_mid
                assign shift_in = entry_w[gi+1];
            end else begin : g_tail
                // Top slot has nothing above it; its stale value is never
                // observed because count_q excludes it.
                assign shift_in = entry_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_q <= '0;
                end else if (push_i && (wr_idx == SKID_CNT_W'(gi))) begin
                    entry_q <= {push_last_i, push_data_i};
                end else if (pop_i) begin
                    entry_q <= shift_in;
                end
            end

            assign entry_w[gi] = entry_q;
        end
    endgenerate

    assign count_o     = count_q;
    assign head_data_o = entry_w[0][DATA_WIDTH-1:0];
    assign head_last_o = entry_w[0][DATA_WIDTH];

endmodule

// File: rtl/bram_stream_reader.sv
// -----------------------------------------------------------------------------
// bram_stream_reader
// Sweeps a contiguous (wrapping) address range of a registered-read BRAM and
// streams the returned words downstream with a last flag.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : command strobe, accepted only while idle
//   base_addr       : first address of the sweep (latched with start)
//   num_words       : words to read, 0..2^ADDR_WIDTH (latched with start)
//   busy            : sweep in progress
//   done            : one-cycle completion pulse
//   bram_addr_read  : BRAM read address
//   bram_data_out   : BRAM read data, valid one cycle after its address
//   m_if            : output stream (master modport)
// Reads are throttled so that words already buffered plus the word in flight
// never exceed the skid FIFO depth; this keeps full rate under continuous
// ready and loses nothing under backpressure.
// -----------------------------------------------------------------------------
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [ADDR_WIDTH:0]     num_words,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   bram_addr_read,
    input  logic [DATA_WIDTH-1:0]   bram_data_out,
    bram_stream_reader_if.master    m_if
);

    rd_state_e               state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;          // next address to issue
    logic [ADDR_WIDTH-1:0]   last_addr_q;     // most recently issued address
    logic [ADDR_WIDTH:0]     left_q;          // addresses still to issue
    logic                    inflight_q;      // read issued last cycle
    logic                    inflight_last_q; // ... and it was the final word
    logic                    busy_q;
    logic                    done_q;

    logic [SKID_CNT_W-1:0]   fifo_count;
    logic [DATA_WIDTH-1:0]   head_data;
    logic                    head_last;
    logic                    fifo_nonempty;

    logic                    pop;
    logic [SKID_CNT_W:0]     occupancy;
    logic                    issue;
    logic                    issue_last;
    logic                    drain_done;

    assign fifo_nonempty = (fifo_count != '0);
    assign pop           = fifo_nonempty && m_if.m_ready;

    // Occupancy the FIFO will have once this cycle's pop and the in-flight
    // capture both retire; a new read is safe only if that leaves a slot.
    always_comb begin
        occupancy  = {1'b0, fifo_count}
                   + (SKID_CNT_W + 1)'(inflight_q)
                   - (SKID_CNT_W + 1)'(pop);
        issue      = (state_q == ST_RUN) && (left_q != '0)
                   && (occupancy < (SKID_CNT_W + 1)'(SKID_DEPTH));
        issue_last = issue && (left_q == (ADDR_WIDTH + 1)'(1));
        // Everything issued has been captured and the FIFO empties this
        // cycle, so the final beat is transferring now.
        drain_done = !inflight_q && (fifo_count == SKID_CNT_W'(pop));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            last_addr_q     <= '0;
            left_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue_last;

            if (issue) begin
                addr_q      <= addr_q + ADDR_WIDTH'(1);
                last_addr_q <= addr_q;
                left_q      <= left_q - (ADDR_WIDTH + 1)'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_q  <= base_addr;
                        left_q  <= num_words;
                        busy_q  <= 1'b1;
                        state_q <= (num_words == '0) ? ST_FIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (issue_last) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    // Arriving from DRAIN the pulse is already up; an empty
                    // sweep arrives straight from IDLE and raises it here,
                    // so its pulse lands one cycle later.
                    if (done_q) begin
                        done_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    bram_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (bram_data_out),
        .push_last_i (inflight_last_q),
        .pop_i       (pop),
        .count_o     (fifo_count),
        .head_data_o (head_data),
        .head_last_o (head_last)
    );

    // The address only changes when a read is issued; otherwise it holds the
    // last issued address. Captures are qualified by inflight_q either way.
    assign bram_addr_read = issue ? addr_q : last_addr_q;
    assign busy           = busy_q;
    assign done           = done_q;

    assign m_if.m_data    = head_data;
    assign m_if.m_valid   = fifo_nonempty;
    assign m_if.m_last    = head_last && fifo_nonempty;

endmodule

// File: tb/tb_bram_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_bram_stream_reader
// Drives sweeps into bram_stream_reader backed by a registered-read memory
// preloaded with mem[i] = i + 100, and compares the stream against a list of
// expected words built from base/num with wrap-around arithmetic.
// -----------------------------------------------------------------------------
module tb_bram_stream_reader;

    localparam int DW    = 18;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic          busy;
    logic          done;
    logic [AW-1:0] bram_addr_read;
    logic [DW-1:0] bram_data_out;

    bram_stream_reader_if #(.DATA_WIDTH(DW)) s_if ();

    bram_stream_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .base_addr      (base_addr),
        .num_words      (num_words),
        .busy           (busy),
        .done           (done),
        .bram_addr_read (bram_addr_read),
        .bram_data_out  (bram_data_out),
        .m_if           (s_if)
    );

    // Coefficient store: registered read, one cycle latency, no enable.
    logic [DW-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 100);
    end
    always @(posedge clk) bram_data_out <= mem[bram_addr_read];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One sweep from IDLE. mode 0: ready always high; 1: random ready;
    // 2: random ready plus a 10-cycle stall once 20 beats have passed.
    // dup: pulse start again mid-sweep with different arguments.
    // timing: check first-valid and done cycles (only meaningful with mode 0).
    task automatic run_sweep(input int base, input int num, input int mode,
                             input bit dup, input bit timing);
        logic [DW:0]   exp_q[$];
        logic [DW:0]   e;
        int            beats;
        int            first_valid;
        int            done_cyc;
        int            stall_left;
        bit            stalled_once;
        bit            prev_stall;
        logic [DW-1:0] prev_data;
        logic          prev_last;

        for (int i = 0; i < num; i++)
            exp_q.push_back({(i == num - 1), DW'(((base + i) % DEPTH) + 100)});

        beats = 0; first_valid = -1; done_cyc = -1; stall_left = 0;
        stalled_once = 0; prev_stall = 0; prev_data = '0; prev_last = 0;

        start     = 1'b1;
        base_addr = AW'(base);
        num_words = (AW + 1)'(num);

        for (int c = 0; c < 4000 && done_cyc < 0; c++) begin
            if (c == 1) start = 1'b0;
            if (dup && c == 2) begin
                start     = 1'b1;
                base_addr = AW'(base + 300);
                num_words = (AW + 1)'(7);
            end
            if (dup && c == 3) start = 1'b0;

            if (mode == 0) begin
                s_if.m_ready = 1'b1;
            end else begin
                if (mode == 2 && !stalled_once && beats >= 20) begin
                    stalled_once = 1;
                    stall_left   = 10;
                end
                if (stall_left > 0) begin
                    s_if.m_ready = 1'b0;
                    stall_left--;
                end else begin
                    s_if.m_ready = ($urandom_range(0, 3) != 0);
                end
            end

            @(negedge clk);
            if (prev_stall) begin
                check("hold_valid", s_if.m_valid, 1);
                check("hold_data",  s_if.m_data,  prev_data);
                check("hold_last",  s_if.m_last,  prev_last);
            end
            if (s_if.m_valid && first_valid < 0) first_valid = c;
            if (s_if.m_valid && s_if.m_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("data", s_if.m_data, e[DW-1:0]);
                    check("last", s_if.m_last, e[DW]);
                end
                beats++;
            end
            prev_stall = s_if.m_valid && !s_if.m_ready;
            prev_data  = s_if.m_data;
            prev_last  = s_if.m_last;

            if (done) begin
                check("busy_at_done", busy, 0);
                done_cyc = c;
            end else if (c >= 1) begin
                check("busy_run", busy, 1);
            end else begin
                check("busy_c0", busy, 0);
            end
            @(posedge clk); #1;
        end

        if (done_cyc < 0) check("done_timeout", 0, 1);
        check("beat_count", beats, num);
        check("words_left", exp_q.size(), 0);
        if (timing) begin
            if (num > 0) begin
                check("first_valid_cyc", first_valid, 3);
                check("done_cyc", done_cyc, num + 3);
            end else begin
                check("first_valid_cyc", first_valid, -1);
                check("done_cyc", done_cyc, 2);
            end
        end

        // Done is a single-cycle pulse and the stream stays quiet afterwards.
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle_valid", s_if.m_valid, 0);
        @(posedge clk); #1;

        $display("[TB] sweep base=%0d num=%0d mode=%0d dup=%0d beats=%0d done_cyc=%0d",
                 base, num, mode, dup, beats, done_cyc);
    endtask

    initial begin
        int beats;

        rst          = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        num_words    = '0;
        s_if.m_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_valid", s_if.m_valid, 0);
        check("rst_last",  s_if.m_last, 0);
        check("rst_data",  s_if.m_data, 0);
        check("rst_addr",  bram_addr_read, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_sweep(5,    4,  0, 0, 1);
        run_sweep(1022, 4,  0, 0, 1);
        run_sweep(100,  64, 2, 0, 0);
        run_sweep(7,    0,  0, 0, 1);

        // Reset in the middle of a sweep once three beats have gone out.
        start = 1'b1; base_addr = AW'(5); num_words = (AW + 1)'(20);
        s_if.m_ready = 1'b1;
        beats = 0;
        for (int c = 0; c < 50 && beats < 3; c++) begin
            if (c == 1) start = 1'b0;
            @(negedge clk);
            if (s_if.m_valid && s_if.m_ready) beats++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("pre_rst_beats", beats, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", s_if.m_valid, 0);
        check("midrst_busy",  busy, 0);
        check("midrst_done",  done, 0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("post_rst_quiet", s_if.m_valid, 0);
        end
        @(posedge clk); #1;
        run_sweep(0, 2, 0, 0, 1);

        // Second start during RUN must be ignored.
        run_sweep(200, 10, 0, 1, 1);

        for (int k = 0; k < 4; k++)
            run_sweep($urandom_range(0, DEPTH - 1), $urandom_range(1, 48), 1, 0, 0);

        run_sweep($urandom_range(0, DEPTH - 1), DEPTH, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side client for the team's block-RAM coefficient store (dual-port, registered read, 1-cycle read latency, no read enable).
- On a start command it sweeps a contiguous address range, captures each returned word exactly one cycle after its address is issued, and presents the words as a valid/ready stream with a last flag.
- Full throughput under continuous ready; no word is lost or duplicated under arbitrary backpressure.
- Sits between a coefficient BRAM and downstream DFT/NTT datapath stages.

Parameters:
- DATA_WIDTH, 18, width of one coefficient word; must match the attached BRAM.
- ADDR_WIDTH, 10, BRAM address width; depth = 2^ADDR_WIDTH words.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle command strobe; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first address of the sweep; latched with start.
- num_words  input  ADDR_WIDTH+1  words to read, 0..2^ADDR_WIDTH; latched with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the sweep is complete.
- bram_addr_read  output  ADDR_WIDTH  drives the BRAM read address.
- bram_data_out  input  DATA_WIDTH  BRAM registered read data.
- m_data  output  DATA_WIDTH  stream data (FIFO head, driven from registers).
- m_valid  output  1  stream valid.
- m_last  output  1  high with the final word of the sweep.
- m_ready  input  1  downstream ready; a beat transfers when m_valid && m_ready.

Behaviour:
- Reset: busy=0, done=0, m_valid=0, m_last=0, m_data=0, bram_addr_read=0, FSM=IDLE, FIFO empty, in-flight flag cleared.
- Reset mid-sweep: same as above on the next edge. In-flight BRAM data is discarded and no further beats are emitted.
- FSM states and transitions:
  - IDLE: start=1 latches base_addr/num_words. If num_words=0, go to FIN; otherwise go to RUN.
  - RUN: issues reads until all num_words addresses are issued, then goes to DRAIN.
  - DRAIN: waits until the FIFO is empty, nothing is in flight, and the last beat has transferred, then goes to FIN.
  - FIN: done=1 for exactly one cycle, busy=0, return to IDLE.
- start while not in IDLE is ignored.
- Issue rule, cycle t in RUN: issue iff (fifo_count + inflight − pop) < 2.
  - pop = m_valid && m_ready.
  - inflight = a read was issued at t−1.
  - On issue, bram_addr_read = next address. The address increments modulo 2^ADDR_WIDTH, so base 1023 with 3 words reads 1023, 0, 1.
- Capture: when inflight=1, bram_data_out is pushed into a 2-entry FIFO at the end of that cycle, together with a last flag for the final word. Push and pop in the same cycle are legal.
- The 2-entry FIFO guarantees no overflow under any m_ready pattern.
- Latency: with start at cycle 0, the first address is issued at cycle 1, data is on bram_data_out at cycle 2, and m_valid=1 at cycle 3.
- Throughput: with m_ready held high, one beat per cycle after the first.
- Stream stability: m_data and m_last are held stable while m_valid && !m_ready.
- done timing: done pulses the cycle after the last-beat transfer. num_words=0 gives done at cycle 2 after start with no beats.
- bram_addr_read holds its last value when not issuing. This is harmless because captures are qualified by inflight.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, RUN, DRAIN, FIN).
  - Constant SKID_DEPTH=2.
  - Default DATA_WIDTH/ADDR_WIDTH constants shared with the BRAM wrapper.
- One sub-module: bram_rd_skid.
  - 2-entry register FIFO carrying {last, data}.
  - Ports for push, pop, count, head outputs.
  - Synchronous active-high reset.

Test Plan:
- Preload the BRAM with mem[i]=i+100. start, base=5, num=4, m_ready=1 → m_valid cycles 3–6, data 105,106,107,108, m_last on 108, done at cycle 7.
- base=1022, num=4 → data from addresses 1022,1023,0,1 in order; wrap-around is correct.
- num=64 with m_ready toggling randomly, plus m_ready=0 held for 10 cycles mid-stream → all 64 words exactly once, in order. Data is stable during stall, and the FIFO never exceeds 2.
- num=0 → no m_valid, done pulse at cycle 2, busy low throughout except that window per the rule above.
- rst asserted mid-sweep after 3 beats → next cycle m_valid=0, busy=0, done=0. A subsequent start with base=0, num=2 streams 100,101 cleanly.
- start pulsed again during RUN with a different base → ignored; the original sweep completes unchanged.
